// File: rtl/line_memory_pkg.sv
// Shared widths and request/response records for the line-granular backing memory.
package mem_pkg;

  localparam int unsigned MEM_PA_WIDTH   = 32;
  localparam int unsigned MEM_LINE_WIDTH = 128;
  localparam int unsigned MEM_ID_WIDTH   = 2;

  typedef struct packed {
    logic                      write;
    logic [MEM_PA_WIDTH-1:0]   addr;
    logic [MEM_LINE_WIDTH-1:0] data;
    logic [MEM_ID_WIDTH-1:0]   id;
  } mem_req_t;

  typedef struct packed {
    logic [MEM_LINE_WIDTH-1:0] data;
    logic [MEM_ID_WIDTH-1:0]   id;
  } mem_resp_t;

endpackage

// File: rtl/line_memory_resp_fifo.sv
// Response FIFO with a registered head entry; push and pop may coincide at any occupancy.
module resp_fifo #(
  parameter int unsigned WIDTH = 130,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next;
  logic [PTR_W:0]   count_q;
  logic [WIDTH-1:0] head_q;
  logic             do_pop;

  assign do_pop    = pop && (count_q != '0);
  assign rd_next   = rd_ptr + 1'b1;
  assign head_data = head_q;
  assign valid     = (count_q != '0);
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // head_q mirrors mem[rd_ptr]; a push into an empty (or draining) FIFO bypasses straight to it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_next;
      count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, do_pop};
      if (count_q == '0) begin
        if (push) head_q <= push_data;
      end else if (do_pop) begin
        if (count_q == (PTR_W+1)'(1)) begin
          if (push) head_q <= push_data;
        end else begin
          head_q <= mem[rd_next];
        end
      end
    end
  end

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line memory with credit-limited read responses.
// Define LINE_MEMORY_STATS_EN to build the saturating read/write/full-cycle counters.
module line_memory
  import mem_pkg::*;
#(
  parameter int unsigned PA_WIDTH   = MEM_PA_WIDTH,
  parameter int unsigned LINE_WIDTH = MEM_LINE_WIDTH,
  parameter int unsigned ID_WIDTH   = MEM_ID_WIDTH,
  parameter int unsigned STAGES     = 4,
  parameter int unsigned MEM_LINES  = 1024,
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_enable,
  input  logic                  i_mem_write,
  input  logic [PA_WIDTH-1:0]   i_mem_addr,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic [ID_WIDTH-1:0]   i_mem_id,
  input  logic                  i_mem_ack,
  output logic                  o_mem_enable,
  output logic [LINE_WIDTH-1:0] o_mem_data,
  output logic [ID_WIDTH-1:0]   o_mem_id_response,
  output logic                  o_mem_full,
  output logic [31:0]           o_stat_reads,
  output logic [31:0]           o_stat_writes,
  output logic [31:0]           o_stat_full_cycles
);

  localparam int unsigned IDX_W = $clog2(MEM_LINES);
  localparam int unsigned CNT_W = $clog2(RESP_DEPTH) + 1;

  mem_req_t              pipe_req [STAGES];
  logic [STAGES-1:0]     pipe_valid;
  logic [LINE_WIDTH-1:0] array [MEM_LINES];

  mem_req_t   in_req, exit_req;
  mem_resp_t  push_resp, head_resp;
  logic [IDX_W-1:0] exit_idx;
  logic [CNT_W-1:0] inflight, fifo_count, credit;
  logic accept, read_accept, exit_valid, exit_read, pop;
  logic unused_addr;

  assign credit      = inflight + fifo_count;
  assign o_mem_full  = (credit == CNT_W'(RESP_DEPTH));
  assign accept      = i_mem_enable && (i_mem_write || !o_mem_full);
  assign read_accept = accept && !i_mem_write;
  assign pop         = i_mem_ack && o_mem_enable;

  assign in_req = '{write: i_mem_write, addr: i_mem_addr, data: i_mem_data, id: i_mem_id};

  assign exit_req    = pipe_req[STAGES-1];
  assign exit_valid  = pipe_valid[STAGES-1];
  assign exit_read   = exit_valid && !exit_req.write;
  assign exit_idx    = exit_req.addr[IDX_W-1:0];
  assign unused_addr = ^exit_req.addr;
  // Combinational array read sees the pre-edge contents, so a same-edge write never leaks in
  assign push_resp   = '{data: array[exit_idx], id: exit_req.id};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int unsigned s = 1; s < STAGES; s++) pipe_valid[s] <= pipe_valid[s-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_req[0] <= in_req;
    for (int unsigned s = 1; s < STAGES; s++) pipe_req[s] <= pipe_req[s-1];
  end

  always_ff @(posedge clk) begin
    if (exit_valid && exit_req.write) array[exit_idx] <= exit_req.data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= '0;
    else     inflight <= inflight + CNT_W'(read_accept) - CNT_W'(exit_read);
  end

  resp_fifo #(
    .WIDTH ($bits(mem_resp_t)),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (exit_read),
    .push_data (push_resp),
    .pop       (pop),
    .head_data (head_resp),
    .valid     (o_mem_enable),
    .count     (fifo_count)
  );

  assign o_mem_data        = head_resp.data;
  assign o_mem_id_response = head_resp.id;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (credit <= CNT_W'(RESP_DEPTH))
        else $error("line_memory: credit count exceeds response depth");
      assert (!(i_mem_enable && !i_mem_write && o_mem_full))
        else $error("line_memory: read request dropped while full");
    end
  end

`ifdef LINE_MEMORY_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_full   <= '0;
    end else begin
      if (read_accept && (stat_reads != '1))                stat_reads  <= stat_reads + 1'b1;
      if (accept && i_mem_write && (stat_writes != '1))     stat_writes <= stat_writes + 1'b1;
      if (o_mem_full && (stat_full != '1))                  stat_full   <= stat_full + 1'b1;
    end
  end

  assign o_stat_reads       = stat_reads;
  assign o_stat_writes      = stat_writes;
  assign o_stat_full_cycles = stat_full;
`else
  assign o_stat_reads       = '0;
  assign o_stat_writes      = '0;
  assign o_stat_full_cycles = '0;
`endif

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: latency, ordering, credit limit, simultaneous push/pop, reset, stats.
module tb_line_memory;

  localparam int unsigned LW = 128;

`ifdef LINE_MEMORY_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_mem_enable, i_mem_write, i_mem_ack;
  logic [31:0]   i_mem_addr;
  logic [LW-1:0] i_mem_data;
  logic [1:0]    i_mem_id;
  logic          o_mem_enable, o_mem_full;
  logic [LW-1:0] o_mem_data;
  logic [1:0]    o_mem_id_response;
  logic [31:0]   o_stat_reads, o_stat_writes, o_stat_full_cycles;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  line_memory #(
    .PA_WIDTH   (32),
    .LINE_WIDTH (LW),
    .ID_WIDTH   (2),
    .STAGES     (4),
    .MEM_LINES  (1024),
    .RESP_DEPTH (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_mem_enable       (i_mem_enable),
    .i_mem_write        (i_mem_write),
    .i_mem_addr         (i_mem_addr),
    .i_mem_data         (i_mem_data),
    .i_mem_id           (i_mem_id),
    .i_mem_ack          (i_mem_ack),
    .o_mem_enable       (o_mem_enable),
    .o_mem_data         (o_mem_data),
    .o_mem_id_response  (o_mem_id_response),
    .o_mem_full         (o_mem_full),
    .o_stat_reads       (o_stat_reads),
    .o_stat_writes      (o_stat_writes),
    .o_stat_full_cycles (o_stat_full_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic wr, input logic [31:0] addr,
                       input logic [7:0] b, input logic [1:0] id, input logic ack);
    i_mem_enable = en;
    i_mem_write  = wr;
    i_mem_addr   = addr;
    i_mem_data   = fill(b);
    i_mem_id     = id;
    i_mem_ack    = ack;
  endtask

  initial begin
    drive(0, 0, 0, 8'h00, 0, 0);
    rst = 1'b0;
    #1 rst = 1'b1;
    tick();
    chk("rst_enable", o_mem_enable, 0);
    chk("rst_data", o_mem_data, 0);
    chk("rst_id", o_mem_id_response, 0);
    chk("rst_full", o_mem_full, 0);
    chk("rst_stat_reads", o_stat_reads, 0);
    rst = 1'b0;

    // write then read, same line
    drive(1, 1, 32'h5, 8'hA5, 0, 0); tick();
    drive(1, 0, 32'h5, 8'h00, 2, 0); tick();
    drive(0, 0, 0, 8'h00, 0, 0);
    tick(); tick(); tick();
    chk("lat_not_yet", o_mem_enable, 0);
    tick();
    chk("lat_enable", o_mem_enable, 1);
    chk("lat_data", o_mem_data, fill(8'hA5));
    chk("lat_id", o_mem_id_response, 2);
    chk("lat_full", o_mem_full, 0);
    drive(0, 0, 0, 8'h00, 0, 1); tick();
    drive(0, 0, 0, 8'h00, 0, 0);
    chk("lat_popped", o_mem_enable, 0);

    // ordering: three reads acked one per cycle
    drive(1, 1, 32'h1, 8'h11, 0, 0); tick();
    drive(1, 1, 32'h2, 8'h22, 0, 0); tick();
    drive(1, 1, 32'h3, 8'h33, 0, 0); tick();
    drive(1, 0, 32'h1, 8'h00, 0, 0); tick();
    drive(1, 0, 32'h2, 8'h00, 1, 0); tick();
    drive(1, 0, 32'h3, 8'h00, 2, 0); tick();
    drive(0, 0, 0, 8'h00, 0, 0);
    tick(); tick();
    chk("ord0_enable", o_mem_enable, 1);
    chk("ord0_id", o_mem_id_response, 0);
    chk("ord0_data", o_mem_data, fill(8'h11));
    drive(0, 0, 0, 8'h00, 0, 1); tick();
    chk("ord1_id", o_mem_id_response, 1);
    chk("ord1_data", o_mem_data, fill(8'h22));
    tick();
    chk("ord2_id", o_mem_id_response, 2);
    chk("ord2_data", o_mem_data, fill(8'h33));
    tick();
    drive(0, 0, 0, 8'h00, 0, 0);
    chk("ord_empty", o_mem_enable, 0);
    chk("ord_credit_back", o_mem_full, 0);

    // credit fill: four reads, no acks
    drive(1, 0, 32'h1, 8'h00, 0, 0); tick();
    drive(1, 0, 32'h2, 8'h00, 1, 0); tick();
    drive(1, 0, 32'h3, 8'h00, 2, 0); tick();
    chk("fill_3_not_full", o_mem_full, 0);
    drive(1, 0, 32'h5, 8'h00, 3, 0); tick();
    chk("fill_4_full", o_mem_full, 1);
    drive(1, 1, 32'h7, 8'h77, 0, 0); tick();
    chk("fill_write_full", o_mem_full, 1);
    drive(0, 0, 0, 8'h00, 0, 0);
    tick(); tick();
    // ack the head while the fourth read exits
    drive(0, 0, 0, 8'h00, 0, 1); tick();
    chk("sim_enable", o_mem_enable, 1);
    chk("sim_id", o_mem_id_response, 1);
    chk("sim_data", o_mem_data, fill(8'h22));
    chk("sim_full_drop", o_mem_full, 0);
    drive(1, 0, 32'h7, 8'h00, 0, 1); tick();
    chk("sim_id2", o_mem_id_response, 2);
    chk("sim_data2", o_mem_data, fill(8'h33));
    drive(0, 0, 0, 8'h00, 0, 1); tick();
    chk("sim_id3", o_mem_id_response, 3);
    chk("sim_data3", o_mem_data, fill(8'hA5));
    tick();
    drive(0, 0, 0, 8'h00, 0, 0);
    chk("sim_drained", o_mem_enable, 0);
    tick(); tick();
    chk("wfull_enable", o_mem_enable, 1);
    chk("wfull_id", o_mem_id_response, 0);
    chk("wfull_data", o_mem_data, fill(8'h77));
    drive(0, 0, 0, 8'h00, 0, 1); tick();
    drive(0, 0, 0, 8'h00, 0, 0);
    chk("wfull_empty", o_mem_enable, 0);
    chk("wfull_credit", o_mem_full, 0);

    // reset with one queued response and two reads in flight
    drive(1, 0, 32'h1, 8'h00, 1, 0); tick();
    drive(1, 0, 32'h2, 8'h00, 2, 0); tick();
    drive(1, 0, 32'h3, 8'h00, 3, 0); tick();
    drive(0, 0, 0, 8'h00, 0, 0);
    tick(); tick();
    chk("prerst_id", o_mem_id_response, 1);
    chk("prerst_data", o_mem_data, fill(8'h11));
    #3 rst = 1'b1;
    #1;
    chk("midrst_enable", o_mem_enable, 0);
    chk("midrst_data", o_mem_data, 0);
    chk("midrst_id", o_mem_id_response, 0);
    chk("midrst_full", o_mem_full, 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("postrst_enable", o_mem_enable, 0);
    chk("postrst_full", o_mem_full, 0);
    chk("postrst_stat_reads", o_stat_reads, 0);
    chk("postrst_stat_writes", o_stat_writes, 0);
    chk("postrst_stat_full", o_stat_full_cycles, 0);

    // stats: 2 writes, 4 reads, 5 cycles full
    drive(1, 1, 32'h9, 8'h99, 0, 0); tick();
    drive(1, 1, 32'hA, 8'hAA, 0, 0); tick();
    drive(1, 0, 32'h1, 8'h00, 0, 0); tick();
    drive(1, 0, 32'h2, 8'h00, 1, 0); tick();
    drive(1, 0, 32'h3, 8'h00, 2, 0); tick();
    drive(1, 0, 32'h5, 8'h00, 3, 0); tick();
    drive(0, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    drive(0, 0, 0, 8'h00, 0, 1); tick();
    chk("stat_reads", o_stat_reads, STATS_ON ? 4 : 0);
    chk("stat_writes", o_stat_writes, STATS_ON ? 2 : 0);
    chk("stat_full_cycles", o_stat_full_cycles, STATS_ON ? 5 : 0);
    chk("stat_head_id", o_mem_id_response, 1);
    tick(); tick(); tick();
    drive(0, 0, 0, 8'h00, 0, 0);
    chk("stat_drained", o_mem_enable, 0);
    chk("stat_credit", o_mem_full, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
